bram_port_arbiter: RTL
======================

Name: bram_port_arbiter

Overview:
- Shares the single-port 1024x8 record BRAM between three requesters:
  - 0: eth RX payload loader
  - 1: checksum calculator
  - 2: eth TX/reply sender
- One access per cycle, round-robin between requesters.
- A requester can lock the port for a burst of up to MAX_BURST cycles, after which the lock is force-released.
- Sits between the packet handler FSM/checksum engine and the bram instance. Replaces the ad-hoc OR-ing of memory signals.

Parameters:
- ADDR_W, 10, BRAM address width
- DATA_W, 8, BRAM data width
- MAX_BURST, 64, max consecutive granted cycles under lock before forced release (>=2)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  3  per-requester access request (bit k = requester k)
- i_lock  in  3  per-requester lock request; only meaningful with i_req
- i_we  in  3  per-requester write enable (1 = write, 0 = read)
- i_addr  in  3*ADDR_W  per-requester address; requester k at bits [k*ADDR_W +: ADDR_W]
- i_wdata  in  3*DATA_W  per-requester write data, packed the same way
- o_gnt  out  3  one-hot grant; access is performed in the cycle o_gnt[k]=1
- o_rvalid  out  3  read data valid for requester k, one cycle after its granted read
- o_rdata  out  DATA_W  read data, shared by all requesters; qualified by o_rvalid
- o_mem_en  out  1  BRAM enable
- o_mem_we  out  1  BRAM write enable
- o_mem_addr  out  ADDR_W  BRAM address
- o_mem_wdata  out  DATA_W  BRAM write data
- i_mem_rdata  in  DATA_W  BRAM read data (1-cycle latency)
- o_owner  out  2  current lock owner index; 3 = no owner
- o_busy  out  1  1 while a lock is held

Behaviour:
- Reset (async, i_rst_n=0):
  - state=ARB, rr pointer=0 (priority order 0,1,2), burst_cnt=0, o_owner=3.
  - o_busy=0, o_rvalid=0.
  - o_gnt=0 and o_mem_en=0 while reset is asserted.
  - Reset mid-burst drops the lock immediately. No pending rvalid survives reset.
- Grant logic is combinational from i_req and registered state. At most one o_gnt bit is set per cycle.
- Memory signals are driven combinationally from the granted requester:
  - o_mem_en=|o_gnt.
  - o_mem_we/addr/wdata are taken from the granted requester.
  - With no grant: o_mem_we=0, addr=0, wdata=0.
- o_rvalid[k] is registered: 1 in the cycle after o_gnt[k]=1 with i_we[k]=0, else 0.
- o_rdata=i_mem_rdata, passed straight through.
- State ARB:
  - Grant the first requesting index starting at the rr pointer, wrapping 2->0.
  - After granting k, the rr pointer becomes (k+1) mod 3.
  - If the granted k also has i_lock[k]=1: go to LOCKED, owner=k, burst_cnt=1.
- State LOCKED (owner k):
  - If i_req[k]=1, i_lock[k]=1 and burst_cnt<MAX_BURST: grant only k, burst_cnt+=1. Other requesters wait, with no grant.
  - If i_req[k]=0 or i_lock[k]=0: release in the same cycle. Arbitrate as in ARB, with k excluded from this cycle's grant. Next state follows the ARB rules.
  - If burst_cnt==MAX_BURST (forced release): k is not granted this cycle. Another pending requester is granted by round-robin, otherwise no grant. Next state is ARB with the rr pointer at (k+1) mod 3. burst_cnt resets to 0.
- A non-owner asserting i_lock while LOCKED has no effect until it wins arbitration.
- Requesters must hold req/we/addr/wdata stable until granted.
- A read and a write in consecutive cycles by different requesters are both legal. The BRAM is not assumed to be write-first.
- o_busy=(state==LOCKED). o_owner holds the owner index while LOCKED, else 3.

Test Plan:
- Reset, then i_req=3'b111, no locks, for 6 cycles -> o_gnt sequence 001,010,100,001,010,100; o_mem_en=1 every cycle.
- Req 1 write addr 10'h005 data 8'hA5, then req 2 read addr 10'h005 -> o_mem_we=1 then 0. o_rvalid=3'b100 one cycle after the read grant, with o_rdata=8'hA5.
- Req 0 holds lock for 20 cycles while req 1 is pending -> o_gnt=001 for 20 cycles, o_busy=1, o_owner=0. On lock drop, the next cycle grants 010.
- MAX_BURST=4; req 0 holds lock indefinitely with req 2 pending -> 4 grants to 0, then one grant to 2, then 0 is re-granted and relocks.
- Assert i_rst_n=0 mid-lock with req 1 pending -> o_gnt=0, o_busy=0, o_owner=3, o_rvalid=0 immediately. After release, the first grant goes to 1 (pointer=0, req0 idle).
- i_req=0 for 5 cycles -> o_mem_en=0, o_gnt=0, no rvalid, and the rr pointer stays unchanged.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares the single-port record BRAM (1024x8 by default) between three
// requesters:
//   0 : eth RX payload loader
//   1 : checksum calculator
//   2 : eth TX/reply sender
// One access per cycle, round-robin between requesters. A requester may lock
// the port for a burst of up to MAX_BURST granted cycles, after which the lock
// is force-released so the others cannot starve.
//
// Handshake (req/gnt): a requester raises i_req[k] and holds i_req[k],
// i_we[k], i_addr[k] and i_wdata[k] stable until it sees o_gnt[k]=1. The
// access is performed in the cycle o_gnt[k]=1 and counts as accepted at the
// end of that cycle. For reads, o_rvalid[k] pulses in the following cycle and
// qualifies the shared o_rdata bus.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req/i_lock/i_we   per-requester request, lock request, write enable
//   i_addr/i_wdata      per-requester address/data, requester k at [k*W +: W]
//   o_gnt               one-hot grant (combinational)
//   o_rvalid            per-requester read-data valid (registered)
//   o_rdata             shared read data (pass-through of i_mem_rdata)
//   o_mem_*             BRAM port, driven from the granted requester
//   i_mem_rdata         BRAM read data, 1-cycle latency
//   o_owner             lock owner index, 3 when no lock is held
//   o_busy              1 while a lock is held
//   o_dbg_state         FSM state (0 = ARB, 1 = LOCKED)
//   o_dbg_rr            round-robin pointer (first index considered next)
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 64
) (
    input  logic                in_dummy_unused_never = 1'b0,
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [2:0]          i_req,
    input  logic [2:0]          i_lock,
    input  logic [2:0]          i_we,
    input  logic [3*ADDR_W-1:0] i_addr,
    input  logic [3*DATA_W-1:0] i_wdata,
    output logic [2:0]          o_gnt,
    output logic [2:0]          o_rvalid,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [1:0]          o_owner,
    output logic                o_busy,
    output logic [0:0]          o_dbg_state,
    output logic [1:0]          o_dbg_rr
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [1:0]       NO_OWNER = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [1:0]       rr_q, rr_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rvalid_q;

    logic [2:0] gnt;
    logic [2:0] own_oh;
    logic [1:0] gnt_idx;
    logic       arb_rules;   // grant taken under ARB rules (pointer update, may lock)

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [1:0] inc_mod3(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    // First requesting index starting at ptr, wrapping 2->0.
    function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                           input logic [1:0] ptr);
        logic [2:0] g;
        logic [1:0] idx;
        g   = '0;
        idx = ptr;
        for (int i = 0; i < 3; i++) begin
            if (g == 3'b000 && req[idx]) begin
                g[idx] = 1'b1;
            end
            idx = inc_mod3(idx);
        end
        return g;
    endfunction

    function automatic logic [1:0] oh_to_idx(input logic [2:0] oh);
        logic [1:0] k;
        case (oh)
            3'b010:  k = 2'd1;
            3'b100:  k = 2'd2;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

    // Owner index 3 shifts out of the vector, giving an empty mask.
    assign own_oh = 3'b001 << owner_q;

    // -------------------------------------------------------------------------
    // Grant and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        gnt       = '0;
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        arb_rules = 1'b0;
        gnt_idx   = 2'd0;

        if (state_q == ST_ARB) begin
            gnt       = rr_pick(i_req, rr_q);
            arb_rules = 1'b1;
        end else begin
            if (i_req[owner_q] && i_lock[owner_q]) begin
                if (cnt_q < CNT_MAX) begin
                    // Burst continues: only the owner is served.
                    gnt   = own_oh;
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    // Forced release: owner sits out this cycle, the others
                    // get one round-robin chance, and any lock request by the
                    // winner is honoured only the next time it wins in ARB.
                    gnt     = rr_pick(i_req & ~own_oh, rr_q);
                    state_d = ST_ARB;
                    owner_d = NO_OWNER;
                    cnt_d   = '0;
                    rr_d    = inc_mod3(owner_q);
                end
            end else begin
                // Voluntary release: arbitrate now without the old owner.
                gnt       = rr_pick(i_req & ~own_oh, rr_q);
                state_d   = ST_ARB;
                owner_d   = NO_OWNER;
                cnt_d     = '0;
                arb_rules = 1'b1;
            end
        end

        if (arb_rules && (gnt != 3'b000)) begin
            gnt_idx = oh_to_idx(gnt);
            rr_d    = inc_mod3(gnt_idx);
            if (i_lock[gnt_idx]) begin
                state_d = ST_LOCKED;
                owner_d = gnt_idx;
                cnt_d   = CNT_ONE;
            end
        end

        // No access may reach the BRAM while reset is held.
        if (!i_rst_n) begin
            gnt = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_ARB;
            rr_q     <= 2'd0;
            owner_q  <= NO_OWNER;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt & ~i_we;
        end
    end

    // -------------------------------------------------------------------------
    // BRAM port mux
    // -------------------------------------------------------------------------
    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            if (gnt[k]) begin
                o_mem_we    = i_we[k];
                o_mem_addr  = i_addr[k*ADDR_W +: ADDR_W];
                o_mem_wdata = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign o_mem_en    = |gnt;
    assign o_gnt       = gnt;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = i_mem_rdata;
    assign o_owner     = owner_q;
    assign o_busy      = (state_q == ST_LOCKED);
    assign o_dbg_state = state_q;
    assign o_dbg_rr    = rr_q;

endmodule
